arm_pipelined_mul_sequencer: RTL

- Multi-cycle iterative multiplier controller for the Execute stage. Sequences MUL and MLA as shift-add steps over a dedicated accumulator.
- Stalls the pipeline while the product is being formed, then returns the result and N/Z flag-write controls in the same 2-bit flag-write encoding the ALU decode path uses.
- Sits beside the ALU; the hazard unit ORs o_Stall into its Fetch/Decode/Execute stall.

---
 rtl/arm_pipelined_mul_pkg.sv | 19 +
 rtl/arm_pipelined_mul_step.sv | 28 ++
 rtl/arm_pipelined_mul_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/arm_pipelined_mul_pkg.sv
// Shared types and constants for the iterative shift-add multiplier sequencer.
// Pure declarations: no latency, no flow control.
// Holds the FSM state encoding, the ALU-compatible flag-write codes and the step-count helper.
package arm_pipelined_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam logic [1:0] FLAG_WRITE_NONE = 2'b00;
    localparam logic [1:0] FLAG_WRITE_NZ   = 2'b10;

    function automatic int mul_steps(input int data_width, input int bits_per_cycle);
        return data_width / bits_per_cycle;
    endfunction

endpackage

// File: rtl/arm_pipelined_mul_step.sv
// One shift-add step retiring BITS_PER_CYCLE multiplier bits.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the next values are registered.
module arm_pipelined_mul_step #(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] mcand,
    input  logic [DATA_WIDTH-1:0] mplier,
    output logic [DATA_WIDTH-1:0] acc_nxt,
    output logic [DATA_WIDTH-1:0] mcand_nxt,
    output logic [DATA_WIDTH-1:0] mplier_nxt
);

    always_comb begin
        acc_nxt = acc;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (mplier[k]) begin
                acc_nxt = acc_nxt + (mcand << k);
            end
        end
    end

    assign mcand_nxt  = mcand << BITS_PER_CYCLE;
    assign mplier_nxt = mplier >> BITS_PER_CYCLE;

endmodule

// File: rtl/arm_pipelined_mul_sequencer.sv
// Iterative MUL/MLA controller beside the ALU; optional early termination via ARM_MUL_EARLY_TERM_EN.
// Latency: start in T gives o_Done in T+STEPS+1 (fewer RUN cycles with early termination).
// Backpressure: o_Stall holds Fetch/Decode/Execute from the accepting cycle through RUN; low in DONE.
module arm_pipelined_mul_sequencer
    import arm_pipelined_mul_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  i_CLK,
    input  logic                  i_NRESET,
    input  logic                  i_Start,
    input  logic                  i_Accumulate,
    input  logic                  i_Set_Flags,
    input  logic                  i_Flush,
    input  logic [DATA_WIDTH-1:0] i_Src_A,
    input  logic [DATA_WIDTH-1:0] i_Src_B,
    input  logic [DATA_WIDTH-1:0] i_Src_Acc,
    output logic                  o_Stall,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic [DATA_WIDTH-1:0] o_Result,
    output logic [1:0]            o_Flags_NZ,
    output logic [1:0]            o_Flag_Write
);

    localparam int STEPS = mul_steps(DATA_WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    mul_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] acc, mcand, mplier;
    logic [DATA_WIDTH-1:0] acc_nxt, mcand_nxt, mplier_nxt;
    logic                  set_flags;
    logic                  last_step;

    arm_pipelined_mul_step #(
        .DATA_WIDTH     (DATA_WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplier     (mplier),
        .acc_nxt    (acc_nxt),
        .mcand_nxt  (mcand_nxt),
        .mplier_nxt (mplier_nxt)
    );

`ifdef ARM_MUL_EARLY_TERM_EN
    // Once no multiplier bits remain, further steps cannot change the accumulator.
    assign last_step = (cnt == LAST_STEP) || (mplier_nxt == '0);
`else
    assign last_step = (cnt == LAST_STEP);
`endif

    assign o_Stall = i_NRESET && (((state == IDLE) && i_Start && !i_Flush) || (state == RUN));
    assign o_Busy  = (state != IDLE);

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            set_flags    <= 1'b0;
            o_Done       <= 1'b0;
            o_Result     <= '0;
            o_Flags_NZ   <= 2'b00;
            o_Flag_Write <= FLAG_WRITE_NONE;
        end else begin
            // Result outputs are a one-cycle strobe; they only carry data in DONE.
            o_Done       <= 1'b0;
            o_Result     <= '0;
            o_Flags_NZ   <= 2'b00;
            o_Flag_Write <= FLAG_WRITE_NONE;
            if (i_Flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_Start) begin
                            acc       <= i_Accumulate ? i_Src_Acc : '0;
                            mcand     <= i_Src_A;
                            mplier    <= i_Src_B;
                            set_flags <= i_Set_Flags;
                            cnt       <= '0;
                            state     <= RUN;
                        end
                    end
                    RUN: begin
                        acc    <= acc_nxt;
                        mcand  <= mcand_nxt;
                        mplier <= mplier_nxt;
                        if (last_step) begin
                            state        <= DONE;
                            cnt          <= '0;
                            o_Done       <= 1'b1;
                            o_Result     <= acc_nxt;
                            o_Flags_NZ   <= {acc_nxt[DATA_WIDTH-1], (acc_nxt == '0)};
                            o_Flag_Write <= set_flags ? FLAG_WRITE_NZ : FLAG_WRITE_NONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
